// File: rtl/mem_fifo_pkg.sv
// rtl/mem_fifo_pkg.sv - shared widths, depth helper and grant encodings for mem_fifo_ctrl
package mem_fifo_pkg;

  localparam int DW_DEF = 4;
  localparam int AW_DEF = 2;

  typedef logic [1:0] gnt_t;

  localparam gnt_t GNT_NONE = 2'd0;
  localparam gnt_t GNT_PUSH = 2'd1;
  localparam gnt_t GNT_POP  = 2'd2;

  function automatic int fifo_depth(input int aw);
    return 1 << aw;
  endfunction

endpackage

// File: rtl/mem_fifo_ctrl_if.sv
// rtl/mem_fifo_ctrl_if.sv - push/pop handshakes and single-port memory bus of mem_fifo_ctrl
interface mem_fifo_ctrl_if
  import mem_fifo_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF
) ();

  logic          push_valid;
  logic [DW-1:0] push_data;
  logic          push_ready;
  logic          pop_req;
  logic          pop_ready;
  logic [DW-1:0] pop_data;
  logic          pop_data_valid;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  // Environment side: producer, consumer and the memory array.
  modport master (
    output push_valid, push_data, pop_req, mem_rdata,
    input  push_ready, pop_ready, pop_data, pop_data_valid,
           mem_we, mem_addr, mem_wdata
  );

  // Controller side.
  modport slave (
    input  push_valid, push_data, pop_req, mem_rdata,
    output push_ready, pop_ready, pop_data, pop_data_valid,
           mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/mem_fifo_arb.sv
// rtl/mem_fifo_arb.sv - one-operation-per-cycle push/pop arbiter with alternating priority
module mem_fifo_arb
  import mem_fifo_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic can_push,
  input  logic can_pop,
  output gnt_t gnt
);

  logic prio;  // 0: push wins a conflict, 1: pop wins

  // Grant: a lone request always wins; a conflict is settled by prio.
  always_comb begin
    gnt = GNT_NONE;
    if (can_push && can_pop) begin
      gnt = prio ? GNT_POP : GNT_PUSH;
    end else if (can_push) begin
      gnt = GNT_PUSH;
    end else if (can_pop) begin
      gnt = GNT_POP;
    end
  end

  // Priority flips only when both sides actually competed.
  always_ff @(posedge clk) begin
    if (rst) begin
      prio <= 1'b0;
    end else if (can_push && can_pop) begin
      prio <= ~prio;
    end
  end

endmodule

// File: rtl/mem_fifo_ctrl.sv
// rtl/mem_fifo_ctrl.sv - FIFO controller over a single-port memory; MEM_FIFO_ERR_FLAGS_EN adds sticky ovf/udf flags
module mem_fifo_ctrl
  import mem_fifo_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  mem_fifo_ctrl_if.slave bus,
  output logic [AW:0]   count,
  output logic          full,
`ifdef MEM_FIFO_ERR_FLAGS_EN
  output logic          empty,
  output logic          ovf_err,
  output logic          udf_err
`else
  output logic          empty
`endif
);

  localparam int DEPTH = fifo_depth(AW);
  localparam logic [AW:0] DEPTH_CNT = DEPTH[AW:0];

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          can_push;
  logic          can_pop;
  gnt_t          gnt;

  assign full  = (count == DEPTH_CNT);
  assign empty = (count == '0);

  // Nothing is offered to the arbiter while reset is held.
  assign can_push = !rst && bus.push_valid && !full;
  assign can_pop  = !rst && bus.pop_req && !empty;

  mem_fifo_arb u_arb (
    .clk      (clk),
    .rst      (rst),
    .can_push (can_push),
    .can_pop  (can_pop),
    .gnt      (gnt)
  );

  // Memory port and ready muxing from the grant; idle parks the address on rd_ptr.
  always_comb begin
    bus.push_ready = 1'b0;
    bus.pop_ready  = 1'b0;
    bus.mem_we     = 1'b0;
    bus.mem_addr   = rd_ptr;
    bus.mem_wdata  = bus.push_data;
    case (gnt)
      GNT_PUSH: begin
        bus.push_ready = 1'b1;
        bus.mem_we     = 1'b1;
        bus.mem_addr   = wr_ptr;
      end
      GNT_POP: begin
        bus.pop_ready = 1'b1;
      end
      default: ;
    endcase
    if (rst) begin
      bus.mem_addr = '0;
    end
  end

  // Pointers, occupancy and the registered read word.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr             <= '0;
      rd_ptr             <= '0;
      count              <= '0;
      bus.pop_data       <= '0;
      bus.pop_data_valid <= 1'b0;
    end else begin
      bus.pop_data_valid <= 1'b0;
      case (gnt)
        GNT_PUSH: begin
          wr_ptr <= wr_ptr + AW'(1);
          count  <= count + (AW+1)'(1);
        end
        GNT_POP: begin
          bus.pop_data       <= bus.mem_rdata;
          bus.pop_data_valid <= 1'b1;
          rd_ptr             <= rd_ptr + AW'(1);
          count              <= count - (AW+1)'(1);
        end
        default: ;
      endcase
    end
  end

`ifdef MEM_FIFO_ERR_FLAGS_EN
  // Sticky misuse flags: a request against a full/empty FIFO latches until reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_err <= 1'b0;
      udf_err <= 1'b0;
    end else begin
      if (bus.push_valid && full) ovf_err <= 1'b1;
      if (bus.pop_req && empty)   udf_err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_fifo_ctrl.sv
// tb/tb_mem_fifo_ctrl.sv - directed self-checking bench for mem_fifo_ctrl
module tb_mem_fifo_ctrl;
  import mem_fifo_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_fifo_ctrl_if #(.DW(4), .AW(2)) bus ();

  logic [2:0] count;
  logic       full;
  logic       empty;
`ifdef MEM_FIFO_ERR_FLAGS_EN
  logic       ovf_err;
  logic       udf_err;
`endif

  mem_fifo_ctrl #(.DW(4), .AW(2)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .count   (count),
    .full    (full),
`ifdef MEM_FIFO_ERR_FLAGS_EN
    .empty   (empty),
    .ovf_err (ovf_err),
    .udf_err (udf_err)
`else
    .empty   (empty)
`endif
  );

  // Memory model: synchronous write, asynchronous read.
  logic [3:0] mem [4];
  always @(posedge clk) begin
    if (bus.mem_we === 1'b1) mem[bus.mem_addr] <= bus.mem_wdata;
  end
  assign bus.mem_rdata = mem[bus.mem_addr];

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [3:0] exp_a [4];

  initial begin
    foreach (mem[i]) mem[i] = 4'h0;
    exp_a[0] = 4'hA; exp_a[1] = 4'hF; exp_a[2] = 4'h5; exp_a[3] = 4'h3;
    bus.push_valid = 1'b0;
    bus.push_data  = 4'h0;
    bus.pop_req    = 1'b0;
    rst = 1'b1;

    // Reset: grants and memory port are quiet while rst is high.
    #1;
    bus.push_valid = 1'b1;
    bus.pop_req    = 1'b1;
    #1;
    chk("rst_push_ready", {7'd0, bus.push_ready}, 8'd0);
    chk("rst_pop_ready",  {7'd0, bus.pop_ready},  8'd0);
    chk("rst_mem_we",     {7'd0, bus.mem_we},     8'd0);
    chk("rst_mem_addr",   {6'd0, bus.mem_addr},   8'd0);
    tick();
    tick();
    bus.push_valid = 1'b0;
    bus.pop_req    = 1'b0;
    rst = 1'b0;
    #1;
    chk("rst_count", {5'd0, count}, 8'd0);
    chk("rst_empty", {7'd0, empty}, 8'd1);
    chk("rst_full",  {7'd0, full},  8'd0);
    chk("rst_pop_data_valid", {7'd0, bus.pop_data_valid}, 8'd0);
    chk("rst_pop_data", {4'd0, bus.pop_data}, 8'd0);

    // 1: four back-to-back pushes fill the FIFO.
    for (int i = 0; i < 4; i++) begin
      bus.push_valid = 1'b1;
      bus.push_data  = exp_a[i];
      #1;
      chk("t1_push_ready", {7'd0, bus.push_ready}, 8'd1);
      chk("t1_mem_we",     {7'd0, bus.mem_we},     8'd1);
      chk("t1_mem_addr",   {6'd0, bus.mem_addr},   8'(i));
      chk("t1_mem_wdata",  {4'd0, bus.mem_wdata},  {4'd0, exp_a[i]});
      tick();
    end
    chk("t1_count", {5'd0, count}, 8'd4);
    chk("t1_full",  {7'd0, full},  8'd1);
    bus.push_data = 4'h9;
    #1;
    chk("t1_push_ready_full", {7'd0, bus.push_ready}, 8'd0);
    chk("t1_mem_we_full",     {7'd0, bus.mem_we},     8'd0);
    bus.push_valid = 1'b0;
    tick();

    // 2: drain in order, one-cycle read latency, rd_ptr wraps.
    for (int i = 0; i < 4; i++) begin
      bus.pop_req = 1'b1;
      #1;
      chk("t2_pop_ready", {7'd0, bus.pop_ready}, 8'd1);
      chk("t2_mem_addr",  {6'd0, bus.mem_addr},  8'(i));
      chk("t2_mem_we",    {7'd0, bus.mem_we},    8'd0);
      tick();
      chk("t2_pop_data",  {4'd0, bus.pop_data},  {4'd0, exp_a[i]});
      chk("t2_pop_valid", {7'd0, bus.pop_data_valid}, 8'd1);
    end
    chk("t2_empty", {7'd0, empty}, 8'd1);
    chk("t2_count", {5'd0, count}, 8'd0);
    #1;
    chk("t2_pop_ready_empty", {7'd0, bus.pop_ready}, 8'd0);
    chk("t2_rd_wrap_addr",    {6'd0, bus.mem_addr},  8'd0);
    tick();
    chk("t2_valid_pulse_end", {7'd0, bus.pop_data_valid}, 8'd0);
    chk("t2_pop_data_hold",   {4'd0, bus.pop_data},       8'h03);
    bus.pop_req = 1'b0;

    // 3: preload 1,2 then hold both requests for four cycles.
    bus.push_valid = 1'b1;
    bus.push_data = 4'h1; tick();
    bus.push_data = 4'h2; tick();
    chk("t3_count_pre", {5'd0, count}, 8'd2);
    bus.pop_req   = 1'b1;
    bus.push_data = 4'h7;
    #1;
    chk("t3_c1_push", {7'd0, bus.push_ready}, 8'd1);
    chk("t3_c1_pop",  {7'd0, bus.pop_ready},  8'd0);
    chk("t3_c1_addr", {6'd0, bus.mem_addr},   8'd2);
    tick();
    chk("t3_c1_count", {5'd0, count}, 8'd3);
    bus.push_data = 4'h8;
    #1;
    chk("t3_c2_push", {7'd0, bus.push_ready}, 8'd0);
    chk("t3_c2_pop",  {7'd0, bus.pop_ready},  8'd1);
    chk("t3_c2_addr", {6'd0, bus.mem_addr},   8'd0);
    tick();
    chk("t3_c2_count", {5'd0, count}, 8'd2);
    chk("t3_c2_data",  {4'd0, bus.pop_data}, 8'h01);
    #1;
    chk("t3_c3_push", {7'd0, bus.push_ready}, 8'd1);
    chk("t3_c3_addr", {6'd0, bus.mem_addr},   8'd3);
    tick();
    chk("t3_c3_count", {5'd0, count}, 8'd3);
    bus.push_valid = 1'b0;
    bus.push_valid = 1'b1;
    bus.push_data  = 4'hC;
    #1;
    chk("t3_c4_push", {7'd0, bus.push_ready}, 8'd0);
    chk("t3_c4_pop",  {7'd0, bus.pop_ready},  8'd1);
    chk("t3_c4_addr", {6'd0, bus.mem_addr},   8'd1);
    tick();
    chk("t3_c4_count", {5'd0, count}, 8'd2);
    chk("t3_c4_data",  {4'd0, bus.pop_data}, 8'h02);
    bus.push_valid = 1'b0;
    tick();
    chk("t3_drain_a", {4'd0, bus.pop_data}, 8'h07);
    tick();
    chk("t3_drain_b", {4'd0, bus.pop_data}, 8'h08);
    bus.pop_req = 1'b0;
    chk("t3_empty", {7'd0, empty}, 8'd1);

    // 4: push and pop requested on an empty FIFO.
    bus.pop_req    = 1'b1;
    bus.push_valid = 1'b1;
    bus.push_data  = 4'h6;
    #1;
    chk("t4_c1_push", {7'd0, bus.push_ready}, 8'd1);
    chk("t4_c1_pop",  {7'd0, bus.pop_ready},  8'd0);
    tick();
    bus.push_valid = 1'b0;
    #1;
    chk("t4_c2_pop",  {7'd0, bus.pop_ready},  8'd1);
    chk("t4_c2_addr", {6'd0, bus.mem_addr},   8'd0);
    tick();
    chk("t4_data",  {4'd0, bus.pop_data},       8'h06);
    chk("t4_valid", {7'd0, bus.pop_data_valid}, 8'd1);
    // Move both pointers to 2 with one extra push/pop at address 1.
    bus.pop_req    = 1'b0;
    bus.push_valid = 1'b1;
    bus.push_data  = 4'hD;
    tick();
    bus.push_valid = 1'b0;
    bus.pop_req    = 1'b1;
    tick();
    chk("t4_extra_data", {4'd0, bus.pop_data}, 8'h0D);
    bus.pop_req = 1'b0;

    // 5: reset after three pushes discards everything.
    bus.push_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.push_data = 4'(i + 4);
      tick();
    end
    bus.push_valid = 1'b0;
    chk("t5_count_pre", {5'd0, count}, 8'd3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("t5_count", {5'd0, count}, 8'd0);
    chk("t5_empty", {7'd0, empty}, 8'd1);
    chk("t5_valid", {7'd0, bus.pop_data_valid}, 8'd0);
    chk("t5_rd_addr", {6'd0, bus.mem_addr}, 8'd0);
    bus.push_valid = 1'b1;
    bus.push_data  = 4'hE;
    #1;
    chk("t5_push_addr", {6'd0, bus.mem_addr}, 8'd0);
    chk("t5_push_we",   {7'd0, bus.mem_we},   8'd1);
    tick();
    bus.push_valid = 1'b0;

`ifdef MEM_FIFO_ERR_FLAGS_EN
    // 6: sticky overflow/underflow flags.
    chk("t6_ovf_init", {7'd0, ovf_err}, 8'd0);
    chk("t6_udf_init", {7'd0, udf_err}, 8'd0);
    bus.push_valid = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    chk("t6_full", {7'd0, full}, 8'd1);
    chk("t6_ovf_before", {7'd0, ovf_err}, 8'd0);
    tick();
    bus.push_valid = 1'b0;
    chk("t6_ovf_set", {7'd0, ovf_err}, 8'd1);
    bus.pop_req = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    chk("t6_ovf_sticky", {7'd0, ovf_err}, 8'd1);
    chk("t6_udf_before", {7'd0, udf_err}, 8'd0);
    tick();
    bus.pop_req = 1'b0;
    chk("t6_udf_set", {7'd0, udf_err}, 8'd1);
    tick();
    chk("t6_udf_sticky", {7'd0, udf_err}, 8'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_ovf_clr", {7'd0, ovf_err}, 8'd0);
    chk("t6_udf_clr", {7'd0, udf_err}, 8'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_fifo_ctrl.md
Name: mem_fifo_ctrl

Overview:
- Upstream controller that turns a small single-port memory into a FIFO. The memory has a 4-bit data path, 4 entries and a synchronous write.
- Drives the memory's we/addr/data_in.
- Consumes the memory's data_out on pops.
- Uses a single address port, so it performs at most one memory operation (push or pop) per cycle, with fair arbitration when both are requested.

Parameters:
- DW, 4, data width; equals the memory data width.
- AW, 2, address width; DEPTH = 2**AW entries (4).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- push_valid  in  1  producer has a word to write.
- push_data  in  DW  word to write.
- push_ready  out  1  push accepted this cycle (combinational).
- pop_req  in  1  consumer requests one word.
- pop_ready  out  1  pop accepted this cycle (combinational).
- pop_data  out  DW  registered read word.
- pop_data_valid  out  1  pop_data valid; one-cycle pulse.
- mem_we  out  1  to memory we.
- mem_addr  out  AW  to memory addr.
- mem_wdata  out  DW  to memory data_in.
- mem_rdata  in  DW  from memory data_out; asynchronous read of mem[mem_addr].
- count  out  AW+1  occupancy, 0..DEPTH.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.

Behaviour:
- Reset (rst high at a rising edge) clears:
  - wr_ptr and rd_ptr to 0;
  - count to 0;
  - prio to 0 (push-first);
  - pop_data to 0 and pop_data_valid to 0.
- While rst is high: push_ready=0, pop_ready=0, mem_we=0 and mem_addr=0.
- Reset mid-operation discards all contents. Memory contents are not cleared, but they are unreachable.
- Candidate signals:
  - can_push = push_valid && !full.
  - can_pop = pop_req && !empty.
- Grant rules:
  - Only can_push: grant push.
  - Only can_pop: grant pop.
  - Both: grant push if prio==0, else grant pop. prio toggles only on these conflict cycles.
- Push grant:
  - push_ready=1, mem_we=1, mem_addr=wr_ptr, mem_wdata=push_data.
  - At the edge: the memory writes, wr_ptr increments and count increments.
- Pop grant:
  - pop_ready=1, mem_we=0, mem_addr=rd_ptr.
  - At the edge: pop_data <= mem_rdata, pop_data_valid <= 1, rd_ptr increments and count decrements.
  - Latency from pop_req accepted to pop_data_valid is 1 cycle.
- No grant: mem_we=0, mem_addr=rd_ptr, mem_wdata=push_data, pop_data_valid <= 0, pop_data holds.
- Pointers are AW bits and wrap modulo DEPTH (3 -> 0).
- count never changes by more than 1 per cycle.
- Full: push_ready=0 regardless of prio; a pending pop is granted.
- Empty: pop_ready=0; a pending push is granted. Data written in cycle N is first poppable in cycle N+1.
- A producer holds push_valid/push_data until push_ready. A consumer holds pop_req until pop_ready. The controller never accepts an op with its ready signal low.

Optional Feature:
- Macro: MEM_FIFO_ERR_FLAGS_EN.
- When defined, two extra outputs are present:
  - ovf_err: sticky; set when push_valid && full.
  - udf_err: sticky; set when pop_req && empty.
  - Both are cleared only by rst.
- When undefined, these ports and registers do not exist and the behaviour is otherwise identical.

Decomposition:
- Package mem_fifo_pkg holds:
  - default DW=4 and AW=2;
  - DEPTH derivation;
  - grant encoding constants GNT_NONE, GNT_PUSH and GNT_POP (2-bit).
- One sub-module, mem_fifo_arb:
  - Combinational grant from can_push, can_pop and prio, plus the prio toggle register.
  - The top holds the pointers, count, read register and memory-port muxing.

Test Plan:
1. Push 4'hA, 4'hF, 4'h5, 4'h3 back-to-back from reset -> mem_addr 0,1,2,3 with mem_we=1; count=4; full=1; push_ready=0 on a 5th push.
2. From full, pop four times -> pop_data 4'hA, 4'hF, 4'h5, 4'h3, each 1 cycle after pop_ready; empty=1 after the 4th pop; rd_ptr wraps to 0.
3. Count=2 with push_valid and pop_req held for 4 cycles -> grants alternate push, pop, push, pop starting with push; count stays within 2..3.
4. Empty with pop_req=1 and push_valid=1 (4'h6) -> cycle 1 grants push only; cycle 2 grants pop (prio=0, no conflict in cycle 1); pop_data=4'h6.
5. Assert rst after 3 pushes -> count=0, empty=1, pop_data_valid=0; the next push lands at mem_addr 0.
6. With MEM_FIFO_ERR_FLAGS_EN defined: push while full -> ovf_err=1 and stays high through later pops; pop while empty -> udf_err=1; both clear only on rst.
